// File: rtl/br_commit_queue.sv
// In-order branch resolution queue: allocates at dispatch, resolves out of order by tag,
// retires one branch per cycle in order and flushes the pipeline on a misprediction.
module br_commit_queue #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_,
    input  logic                     ext_flush_,
    input  logic                     alloc_,
    input  logic                     alloc_pred,
    output logic [$clog2(DEPTH)-1:0] alloc_tag,
    output logic                     full,
    output logic                     empty,
    input  logic                     exe_,
    input  logic [$clog2(DEPTH)-1:0] exe_tag,
    input  logic                     exe_taken,
    output logic                     br_commit_,
    output logic                     br_result,
    output logic                     br_pred_miss_,
    output logic                     flush_
);

    localparam int unsigned TAG = $clog2(DEPTH);
    localparam logic [TAG:0] FULL_CNT = (TAG+1)'(DEPTH);

    typedef enum logic [1:0] {
        FREE,
        PENDING,
        RESOLVED
    } ent_state_t;

    ent_state_t     st         [DEPTH];
    logic           ent_pred   [DEPTH];
    logic           ent_taken  [DEPTH];
    logic [TAG-1:0] head;
    logic [TAG-1:0] tail;
    logic [TAG:0]   count;

    logic commit;
    logic miss;
    logic alloc_ok;
    logic exe_ok;

    assign alloc_tag = tail;
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);

    // Nothing is accepted while a flush (external, or the cycle flush_ is low) is in effect,
    // nor on the edge that registers a mispredicted commit.
    always_comb begin
        commit   = 1'b0;
        miss     = 1'b0;
        alloc_ok = 1'b0;
        exe_ok   = 1'b0;
        commit   = (st[head] == RESOLVED) && flush_ && ext_flush_;
        miss     = commit && (ent_taken[head] != ent_pred[head]);
        alloc_ok = !alloc_ && !full && flush_ && ext_flush_ && !miss;
        exe_ok   = !exe_ && (st[exe_tag] == PENDING) && flush_ && ext_flush_ && !miss;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                st[i]        <= FREE;
                ent_pred[i]  <= 1'b0;
                ent_taken[i] <= 1'b0;
            end
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            br_commit_    <= 1'b1;
            br_result     <= 1'b0;
            br_pred_miss_ <= 1'b1;
            flush_        <= 1'b1;
        end else begin
            br_commit_    <= 1'b1;
            br_pred_miss_ <= 1'b1;
            flush_        <= 1'b1;

            if (!ext_flush_ || miss) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    st[i] <= FREE;
                end
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                // Commit frees head, alloc fills tail and exe only touches PENDING entries,
                // so the three updates never target the same slot.
                if (commit) begin
                    st[head] <= FREE;
                    head     <= head + TAG'(1);
                end
                if (alloc_ok) begin
                    st[tail]       <= PENDING;
                    ent_pred[tail] <= alloc_pred;
                    tail           <= tail + TAG'(1);
                end
                if (exe_ok) begin
                    st[exe_tag]        <= RESOLVED;
                    ent_taken[exe_tag] <= exe_taken;
                end
                if (alloc_ok && !commit) begin
                    count <= count + (TAG+1)'(1);
                end else if (!alloc_ok && commit) begin
                    count <= count - (TAG+1)'(1);
                end
            end

            if (commit) begin
                br_commit_    <= 1'b0;
                br_result     <= ent_taken[head];
                br_pred_miss_ <= !miss;
                flush_        <= !miss;
            end
        end
    end

endmodule

// File: tb/tb_br_commit_queue.sv
// Directed self-checking bench for br_commit_queue (DEPTH = 8).
module tb_br_commit_queue;

    logic       clk = 1'b0;
    logic       reset_;
    logic       ext_flush_;
    logic       alloc_;
    logic       alloc_pred;
    logic [2:0] alloc_tag;
    logic       full;
    logic       empty;
    logic       exe_;
    logic [2:0] exe_tag;
    logic       exe_taken;
    logic       br_commit_;
    logic       br_result;
    logic       br_pred_miss_;
    logic       flush_;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    br_commit_queue #(.DEPTH(8)) dut (
        .clk          (clk),
        .reset_       (reset_),
        .ext_flush_   (ext_flush_),
        .alloc_       (alloc_),
        .alloc_pred   (alloc_pred),
        .alloc_tag    (alloc_tag),
        .full         (full),
        .empty        (empty),
        .exe_         (exe_),
        .exe_tag      (exe_tag),
        .exe_taken    (exe_taken),
        .br_commit_   (br_commit_),
        .br_result    (br_result),
        .br_pred_miss_(br_pred_miss_),
        .flush_       (flush_)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_ = 1'b1;
        exe_   = 1'b1;
    endtask

    task automatic do_alloc(input logic p);
        alloc_     = 1'b0;
        alloc_pred = p;
        exe_       = 1'b1;
        tick();
    endtask

    task automatic do_exe(input logic [2:0] t, input logic tk);
        alloc_    = 1'b1;
        exe_      = 1'b0;
        exe_tag   = t;
        exe_taken = tk;
        tick();
    endtask

    task automatic chk_reset_outs(input string tag);
        check({tag, "_commit"}, {31'd0, br_commit_}, 32'd1);
        check({tag, "_result"}, {31'd0, br_result}, 32'd0);
        check({tag, "_miss"},   {31'd0, br_pred_miss_}, 32'd1);
        check({tag, "_flush"},  {31'd0, flush_}, 32'd1);
        check({tag, "_full"},   {31'd0, full}, 32'd0);
        check({tag, "_empty"},  {31'd0, empty}, 32'd1);
        check({tag, "_tag"},    {29'd0, alloc_tag}, 32'd0);
    endtask

    logic [15:0] pat;

    initial begin
        reset_     = 1'b0;
        ext_flush_ = 1'b1;
        alloc_     = 1'b1;
        alloc_pred = 1'b0;
        exe_       = 1'b1;
        exe_tag    = '0;
        exe_taken  = 1'b0;
        pat        = 16'b1011_0010_1101_0110;

        tick(); tick();
        chk_reset_outs("rst");
        reset_ = 1'b1;
        tick();

        // Fill and drain
        for (int i = 0; i < 8; i++) begin
            alloc_     = 1'b0;
            alloc_pred = 1'b1;
            #0 check("fill_tag", {29'd0, alloc_tag}, i);
            tick();
        end
        idle();
        check("fill_full", {31'd0, full}, 32'd1);
        check("fill_empty", {31'd0, empty}, 32'd0);
        do_alloc(1'b0);
        idle();
        check("ninth_full", {31'd0, full}, 32'd1);
        check("ninth_tag", {29'd0, alloc_tag}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            do_exe(3'(i), 1'b1);
            if (i == 0) begin
                check("drain_lat", {31'd0, br_commit_}, 32'd1);
            end else begin
                check("drain_commit", {31'd0, br_commit_}, 32'd0);
                check("drain_result", {31'd0, br_result}, 32'd1);
                check("drain_miss", {31'd0, br_pred_miss_}, 32'd1);
                check("drain_full", {31'd0, full}, 32'd0);
            end
        end
        idle();
        tick();
        check("drain_last", {31'd0, br_commit_}, 32'd0);
        check("drain_empty", {31'd0, empty}, 32'd1);
        tick();
        check("drain_idle", {31'd0, br_commit_}, 32'd1);

        // Out-of-order resolution: tags 0,1,2 with preds 1,0,1, resolved 2,1,0
        do_alloc(1'b1);
        do_alloc(1'b0);
        do_alloc(1'b1);
        do_exe(3'd2, 1'b1);
        check("ooo_wait2", {31'd0, br_commit_}, 32'd1);
        do_exe(3'd1, 1'b0);
        check("ooo_wait1", {31'd0, br_commit_}, 32'd1);
        do_exe(3'd0, 1'b1);
        check("ooo_wait0", {31'd0, br_commit_}, 32'd1);
        idle();
        tick();
        check("ooo_c0", {30'd0, br_commit_, br_result}, 32'b01);
        tick();
        check("ooo_c1", {30'd0, br_commit_, br_result}, 32'b00);
        check("ooo_c1_miss", {31'd0, br_pred_miss_}, 32'd1);
        tick();
        check("ooo_c2", {30'd0, br_commit_, br_result}, 32'b01);
        tick();
        check("ooo_done", {31'd0, br_commit_}, 32'd1);
        check("ooo_empty", {31'd0, empty}, 32'd1);

        // External flush with 4 pending entries (tags 3..6)
        for (int i = 0; i < 4; i++) do_alloc(1'b1);
        idle();
        check("xf_pre_empty", {31'd0, empty}, 32'd0);
        ext_flush_ = 1'b0;
        tick();
        ext_flush_ = 1'b1;
        check("xf_empty", {31'd0, empty}, 32'd1);
        check("xf_flush", {31'd0, flush_}, 32'd1);
        check("xf_commit", {31'd0, br_commit_}, 32'd1);
        check("xf_tag", {29'd0, alloc_tag}, 32'd0);

        // Mispredict flush: tags 0..3 predicted not-taken, tag 0 resolves taken
        for (int i = 0; i < 4; i++) do_alloc(1'b0);
        do_exe(3'd0, 1'b1);
        idle();
        tick();
        check("mp_commit", {31'd0, br_commit_}, 32'd0);
        check("mp_result", {31'd0, br_result}, 32'd1);
        check("mp_miss", {31'd0, br_pred_miss_}, 32'd0);
        check("mp_flush", {31'd0, flush_}, 32'd0);
        check("mp_empty", {31'd0, empty}, 32'd1);
        check("mp_tag", {29'd0, alloc_tag}, 32'd0);
        alloc_     = 1'b0;
        alloc_pred = 1'b1;
        exe_       = 1'b0;
        exe_tag    = 3'd2;
        exe_taken  = 1'b0;
        tick();
        idle();
        check("mp_flush_1cyc", {31'd0, flush_}, 32'd1);
        check("mp_miss_1cyc", {31'd0, br_pred_miss_}, 32'd1);
        check("mp_alloc_ign", {31'd0, empty}, 32'd1);
        check("mp_alloc_tag", {29'd0, alloc_tag}, 32'd0);
        do_exe(3'd2, 1'b1);
        idle();
        tick();
        check("mp_stale_exe", {31'd0, br_commit_}, 32'd1);

        // Wrap-around: 3 in flight, then 12 resolve/alloc+commit pairs
        for (int n = 0; n < 3; n++) do_alloc(pat[n]);
        for (int k = 0; k < 12; k++) begin
            do_exe(3'(k), pat[k]);
            check("wrap_gap", {31'd0, br_commit_}, 32'd1);
            alloc_     = 1'b0;
            alloc_pred = pat[k+3];
            exe_       = 1'b1;
            #0 check("wrap_tag", {29'd0, alloc_tag}, (k + 3) % 8);
            tick();
            check("wrap_commit", {31'd0, br_commit_}, 32'd0);
            check("wrap_result", {31'd0, br_result}, {31'd0, pat[k]});
            check("wrap_miss", {31'd0, br_pred_miss_}, 32'd1);
            check("wrap_occ", {30'd0, full, empty}, 32'b00);
        end
        idle();
        ext_flush_ = 1'b0;
        tick();
        ext_flush_ = 1'b1;

        // Duplicate exe to a RESOLVED entry: first value wins
        do_alloc(1'b0);
        do_alloc(1'b0);
        do_exe(3'd1, 1'b0);
        do_exe(3'd1, 1'b1);
        do_exe(3'd0, 1'b0);
        idle();
        tick();
        check("dup_c0", {29'd0, br_commit_, br_result, br_pred_miss_}, 32'b001);
        tick();
        check("dup_c1", {29'd0, br_commit_, br_result, br_pred_miss_}, 32'b001);
        check("dup_flush", {31'd0, flush_}, 32'd1);
        tick();
        check("dup_empty", {31'd0, empty}, 32'd1);

        // Alloc while full coincident with a commit is refused (head = tail = 2)
        for (int i = 0; i < 8; i++) do_alloc(1'b1);
        do_exe(3'd2, 1'b1);
        check("af_full", {31'd0, full}, 32'd1);
        do_alloc(1'b1);
        idle();
        check("af_commit", {31'd0, br_commit_}, 32'd0);
        check("af_not_full", {31'd0, full}, 32'd0);
        check("af_tag", {29'd0, alloc_tag}, 32'd2);
        tick();
        check("af_still", {31'd0, full}, 32'd0);

        // Reset asserted mid-drain
        do_exe(3'd3, 1'b1);
        do_exe(3'd4, 1'b1);
        idle();
        check("rd_commit", {30'd0, br_commit_, br_result}, 32'b01);
        #2;
        reset_ = 1'b0;
        #1;
        chk_reset_outs("rd");
        reset_ = 1'b1;
        tick();
        tick();
        check("rd_post", {31'd0, br_commit_}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
